// File: rtl/mem_wb_skid.sv
// MEM->WB register stage with 2-entry skid buffer: 1-cycle latency, 1 entry/cycle.
// Back-pressure: mem_ready is decoded from registered state only, so there is no wb_ready->mem_ready path.
module mem_wb_skid #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NCH    = 1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [NCH*ADDR_W-1:0]  mem_wd,
  input  logic [NCH-1:0]         mem_wreg,
  input  logic [NCH*DATA_W-1:0]  mem_wdata,
  input  logic                   mem_whilo,
  input  logic [DATA_W-1:0]      mem_hi,
  input  logic [DATA_W-1:0]      mem_lo,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [NCH*ADDR_W-1:0]  wb_wd,
  output logic [NCH-1:0]         wb_wreg,
  output logic [NCH*DATA_W-1:0]  wb_wdata,
  output logic                   wb_whilo,
  output logic [DATA_W-1:0]      wb_hi,
  output logic [DATA_W-1:0]      wb_lo,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef struct packed {
    logic [NCH*ADDR_W-1:0] wd;
    logic [NCH-1:0]        wreg;
    logic [NCH*DATA_W-1:0] wdata;
    logic                  whilo;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

  state_t state, state_nxt;
  entry_t head, skid, in_e;
  logic   acc, drn;
  logic   head_from_in, head_from_skid, skid_from_in, head_clear;

  assign in_e      = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                       whilo: mem_whilo, hi: mem_hi, lo: mem_lo};
  assign mem_ready = (state != FULL);
  assign wb_valid  = (state != EMPTY);
  assign acc       = mem_valid & mem_ready;
  assign drn       = wb_valid & wb_ready;

  always_comb begin
    state_nxt      = state;
    head_from_in   = 1'b0;
    head_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    head_clear     = 1'b0;
    if (flush) begin
      state_nxt  = EMPTY;
      head_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          head_from_in = 1'b1;
          state_nxt    = HALF;
        end
        HALF: begin
          if (acc && drn) begin
            head_from_in = 1'b1;
          end else if (acc) begin
            skid_from_in = 1'b1;
            state_nxt    = FULL;
          end else if (drn) begin
            head_clear = 1'b1;
            state_nxt  = EMPTY;
          end
        end
        FULL: if (drn) begin
          head_from_skid = 1'b1;
          state_nxt      = HALF;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Bubbles keep stale addr/data but never carry a write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else if (head_from_in) begin
      head <= in_e;
    end else if (head_from_skid) begin
      head <= skid;
    end else if (head_clear) begin
      head.wreg  <= '0;
      head.whilo <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               skid <= '0;
    else if (skid_from_in) skid <= in_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (wb_valid && !wb_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign wb_wd    = head.wd;
  assign wb_wreg  = head.wreg;
  assign wb_wdata = head.wdata;
  assign wb_whilo = head.whilo;
  assign wb_hi    = head.hi;
  assign wb_lo    = head.lo;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid, built dual-channel with a 4-bit stall counter.
module tb_mem_wb_skid;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NCH    = 2;
  localparam int CNT_W  = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  mem_valid = 1'b0;
  logic                  mem_ready;
  logic [NCH*ADDR_W-1:0] mem_wd = '0;
  logic [NCH-1:0]        mem_wreg = '0;
  logic [NCH*DATA_W-1:0] mem_wdata = '0;
  logic                  mem_whilo = 1'b0;
  logic [DATA_W-1:0]     mem_hi = '0;
  logic [DATA_W-1:0]     mem_lo = '0;
  logic                  wb_valid;
  logic                  wb_ready = 1'b0;
  logic [NCH*ADDR_W-1:0] wb_wd;
  logic [NCH-1:0]        wb_wreg;
  logic [NCH*DATA_W-1:0] wb_wdata;
  logic                  wb_whilo;
  logic [DATA_W-1:0]     wb_hi;
  logic [DATA_W-1:0]     wb_lo;
  logic [CNT_W-1:0]      stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Single-entry stimulus on channel 0, channel 1 idle.
  task automatic drive(input logic [4:0] wd, input logic [31:0] d, input logic hl);
    mem_valid = 1'b1;
    mem_wd    = {5'd0, wd};
    mem_wreg  = 2'b01;
    mem_wdata = {32'd0, d};
    mem_whilo = hl;
    mem_hi    = d + 32'd1;
    mem_lo    = d + 32'd2;
  endtask

  initial begin
    // 1: reset asserted before any clock edge
    #2;
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    chk("rst_wb_wd", 64'(wb_wd), 64'd0);
    chk("rst_wb_wreg", 64'(wb_wreg), 64'd0);
    chk("rst_wb_wdata", wb_wdata, 64'd0);
    chk("rst_hilo", {wb_hi, wb_lo}, 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // 2: back-to-back stream with wb_ready held high
    wb_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(5'(i), 32'(i * 32'h11), 1'b0);
      tick();
      chk("stream_valid", 64'(wb_valid), 64'd1);
      chk("stream_wd", 64'(wb_wd), 64'(i));
      chk("stream_wdata", wb_wdata, 64'(i * 32'h11));
    end
    mem_valid = 1'b0;
    tick();
    chk("stream_end_valid", 64'(wb_valid), 64'd0);
    chk("stream_end_wreg", 64'(wb_wreg), 64'd0);

    // 3: back-pressure fills skid, then drains in order
    do_reset();
    wb_ready = 1'b0;
    drive(5'd10, 32'hA, 1'b0);
    tick();
    chk("bp_a_head", 64'(wb_wd), 64'd10);
    chk("bp_ready_half", 64'(mem_ready), 64'd1);
    drive(5'd11, 32'hB, 1'b0);
    tick();
    chk("bp_ready_full", 64'(mem_ready), 64'd0);
    chk("bp_a_still", 64'(wb_wd), 64'd10);
    drive(5'd12, 32'hC, 1'b0);
    tick();
    tick();
    chk("bp_a_held", wb_wdata, 64'hA);
    chk("bp_stall3", 64'(stall_cnt), 64'd3);
    wb_ready = 1'b1;
    tick();
    chk("bp_b_head", 64'(wb_wd), 64'd11);
    chk("bp_ready_back", 64'(mem_ready), 64'd1);
    tick();
    mem_valid = 1'b0;
    chk("bp_c_head", 64'(wb_wd), 64'd12);
    chk("bp_c_valid", 64'(wb_valid), 64'd1);
    tick();
    chk("bp_drained", 64'(wb_valid), 64'd0);
    chk("bp_stall_final", 64'(stall_cnt), 64'd3);

    // 4: flush while FULL with a new entry presented
    do_reset();
    wb_ready = 1'b0;
    drive(5'd20, 32'h20, 1'b1);
    tick();
    drive(5'd21, 32'h21, 1'b1);
    tick();
    chk("fl_full", 64'(mem_ready), 64'd0);
    drive(5'd22, 32'h22, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_valid = 1'b0;
    chk("fl_valid", 64'(wb_valid), 64'd0);
    chk("fl_wreg", 64'(wb_wreg), 64'd0);
    chk("fl_whilo", 64'(wb_whilo), 64'd0);
    chk("fl_ready", 64'(mem_ready), 64'd1);
    wb_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 64'(wb_valid), 64'd0);

    // 5: dual channel plus HI/LO, ch1 disabled but carried
    do_reset();
    wb_ready  = 1'b0;
    mem_valid = 1'b1;
    mem_wd    = {5'd9, 5'd5};
    mem_wreg  = 2'b01;
    mem_wdata = {32'hBEEF, 32'hDEAD};
    mem_whilo = 1'b1;
    mem_hi    = 32'h1;
    mem_lo    = 32'h2;
    tick();
    mem_valid = 1'b0;
    chk("dual_wd", 64'(wb_wd), 64'({5'd9, 5'd5}));
    chk("dual_wreg", 64'(wb_wreg), 64'd1);
    chk("dual_wdata", wb_wdata, {32'hBEEF, 32'hDEAD});
    chk("dual_whilo", 64'(wb_whilo), 64'd1);
    chk("dual_hilo", {wb_hi, wb_lo}, {32'h1, 32'h2});
    tick();
    chk("dual_hold", wb_wdata, {32'hBEEF, 32'hDEAD});
    // Reset mid-transfer clears outputs without a clock edge
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", 64'(wb_valid), 64'd0);
    chk("mid_rst_wdata", wb_wdata, 64'd0);
    chk("mid_rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // 6: stall counter saturates
    tick();
    wb_ready = 1'b0;
    drive(5'd7, 32'h7, 1'b0);
    tick();
    mem_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 64'(stall_cnt), 64'd15);
    chk("sat_valid", 64'(wb_valid), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
